text_console_writer: RTL and testbench

//  Producer side of the character video buffer: accepts a byte stream (valid/ready), interprets

---
 rtl/video_pkg.sv | 41 ++++
 rtl/vram_fill_copy.sv | 78 +++++++
 rtl/text_console_writer.sv | 169 ++++++++++++++++
 tb/tb_text_console_writer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/video_pkg.sv
// rtl/video_pkg.sv - shared geometry, control codes and writer states for the character buffer
package video_pkg;

    localparam int COLS        = 64;
    localparam int ROWS        = 40;
    localparam int COL_W       = 6;
    localparam int ROW_W       = 6;
    localparam int CHAR_WIDTH  = 8;
    localparam int CHAR_HEIGHT = 8;

    localparam logic [15:0] BASE_ADDR = 16'hF600;
    localparam logic [7:0]  FILL_CHAR = 8'h20;

    // Lengths of the three bulk operations, in bytes
    localparam logic [15:0] BUF_LEN  = 16'(COLS * ROWS);
    localparam logic [15:0] COPY_LEN = 16'(COLS * (ROWS - 1));
    localparam logic [15:0] ROW_LEN  = 16'(COLS);

    localparam logic [COL_W-1:0] COL_LAST = COL_W'(COLS - 1);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(ROWS - 1);

    localparam logic [7:0] CC_BS = 8'h08;
    localparam logic [7:0] CC_LF = 8'h0A;
    localparam logic [7:0] CC_FF = 8'h0C;
    localparam logic [7:0] CC_CR = 8'h0D;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_PUT,
        ST_SCROLL,
        ST_SCROLL_BLANK
    } state_t;

    // COLS is a power of two, so the cell offset is just row and column side by side
    function automatic logic [15:0] cell_addr(input logic [ROW_W-1:0] row,
                                              input logic [COL_W-1:0] col);
        return BASE_ADDR + ((16'(row) << COL_W) | 16'(col));
    endfunction

endpackage

// File: rtl/vram_fill_copy.sv
// rtl/vram_fill_copy.sv - counter-driven fill/copy engine for the video RAM ports
module vram_fill_copy (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        copy,
    input  logic [15:0] src,
    input  logic [15:0] dst,
    input  logic [15:0] len,
    input  logic [7:0]  fill_data,
    input  logic [7:0]  rd_din,
    output logic        rd_en,
    output logic [15:0] rd_addr,
    output logic        wr_en,
    output logic [15:0] wr_addr,
    output logic [7:0]  wr_data,
    output logic        done
);

    logic        copy_q;
    logic [7:0]  fill_q;
    logic [15:0] rd_left;
    logic [15:0] wr_left;

    // In copy mode the byte comes straight from the RAM output register, so a write
    // can follow its read by exactly one cycle
    assign wr_data = copy_q ? rd_din : fill_q;

    // Address counters: done is high during the cycle that carries the final write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            copy_q  <= 1'b0;
            fill_q  <= '0;
            rd_en   <= 1'b0;
            rd_addr <= '0;
            rd_left <= '0;
            wr_en   <= 1'b0;
            wr_addr <= '0;
            wr_left <= '0;
            done    <= 1'b0;
        end else if (start) begin
            copy_q  <= copy;
            fill_q  <= fill_data;
            rd_addr <= src;
            wr_addr <= dst;
            rd_en   <= copy;
            wr_en   <= !copy;
            rd_left <= len - 16'd1;
            wr_left <= len - 16'd1;
            done    <= !copy && (len == 16'd1);
        end else if (copy_q) begin
            wr_en <= rd_en;
            done  <= rd_en && (rd_left == 16'd0);
            if (wr_en) begin
                wr_addr <= wr_addr + 16'd1;
            end
            if (rd_en) begin
                if (rd_left != 16'd0) begin
                    rd_addr <= rd_addr + 16'd1;
                    rd_left <= rd_left - 16'd1;
                end else begin
                    rd_en <= 1'b0;
                end
            end
        end else begin
            done <= wr_en && (wr_left == 16'd1);
            if (wr_en) begin
                if (wr_left != 16'd0) begin
                    wr_addr <= wr_addr + 16'd1;
                    wr_left <= wr_left - 16'd1;
                end else begin
                    wr_en <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/text_console_writer.sv
// rtl/text_console_writer.sv - byte stream to character buffer writer with cursor, wrap and scroll
module text_console_writer
    import video_pkg::*;
(
    input  logic             clk_pixel,
    input  logic             clk_locked,
    input  logic [7:0]       ch_data,
    input  logic             ch_valid,
    output logic             ch_ready,
    output logic [15:0]      wr_addr,
    output logic [7:0]       wr_data,
    output logic             wr_en,
    output logic [15:0]      rd_addr,
    output logic             rd_en,
    input  logic [7:0]       rd_din,
    output logic [COL_W-1:0] cursor_col,
    output logic [ROW_W-1:0] cursor_row,
    output logic             busy
);

    state_t           state_q, state_d;
    logic [COL_W-1:0] col_q, col_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic             boot_q;
    logic             accept;

    logic             eng_start;
    logic             eng_copy;
    logic             eng_done;
    logic [15:0]      eng_src;
    logic [15:0]      eng_dst;
    logic [15:0]      eng_len;
    logic [7:0]       eng_fill;

    assign accept     = ch_valid && ch_ready;
    assign cursor_col = col_q;
    assign cursor_row = row_q;

    // Next state, cursor update and engine launch; every bulk or single write goes through the engine
    always_comb begin
        state_d   = state_q;
        col_d     = col_q;
        row_d     = row_q;
        eng_start = 1'b0;
        eng_copy  = 1'b0;
        eng_src   = BASE_ADDR + ROW_LEN;
        eng_dst   = BASE_ADDR;
        eng_len   = BUF_LEN;
        eng_fill  = FILL_CHAR;
        case (state_q)
            ST_CLEAR: begin
                if (boot_q) begin
                    eng_start = 1'b1;
                end else if (eng_done) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    row_d   = '0;
                end
            end
            ST_IDLE: begin
                if (accept) begin
                    case (ch_data)
                        CC_CR: col_d = '0;
                        CC_BS: begin
                            if (col_q != '0) begin
                                col_d = col_q - 1'b1;
                            end
                        end
                        CC_FF: begin
                            state_d   = ST_CLEAR;
                            eng_start = 1'b1;
                        end
                        CC_LF: begin
                            if (row_q != ROW_LAST) begin
                                row_d = row_q + 1'b1;
                            end else begin
                                state_d   = ST_SCROLL;
                                eng_start = 1'b1;
                                eng_copy  = 1'b1;
                                eng_len   = COPY_LEN;
                            end
                        end
                        default: begin
                            state_d   = ST_PUT;
                            eng_start = 1'b1;
                            eng_dst   = cell_addr(row_q, col_q);
                            eng_len   = 16'd1;
                            eng_fill  = ch_data;
                        end
                    endcase
                end
            end
            ST_PUT: begin
                state_d = ST_IDLE;
                if (col_q != COL_LAST) begin
                    col_d = col_q + 1'b1;
                end else begin
                    col_d = '0;
                    if (row_q != ROW_LAST) begin
                        row_d = row_q + 1'b1;
                    end else begin
                        state_d   = ST_SCROLL;
                        eng_start = 1'b1;
                        eng_copy  = 1'b1;
                        eng_len   = COPY_LEN;
                    end
                end
            end
            ST_SCROLL: begin
                if (eng_done) begin
                    state_d   = ST_SCROLL_BLANK;
                    eng_start = 1'b1;
                    eng_dst   = BASE_ADDR + COPY_LEN;
                    eng_len   = ROW_LEN;
                end
            end
            ST_SCROLL_BLANK: begin
                if (eng_done) begin
                    state_d = ST_IDLE;
                    col_d   = '0;
                    row_d   = ROW_LAST;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                eng_start = 1'b1;
            end
        endcase
    end

    // State, cursor and handshake/status registers; boot_q kicks off the clear after reset
    always_ff @(posedge clk_pixel or negedge clk_locked) begin
        if (!clk_locked) begin
            state_q  <= ST_CLEAR;
            col_q    <= '0;
            row_q    <= '0;
            boot_q   <= 1'b1;
            busy     <= 1'b0;
            ch_ready <= 1'b0;
        end else begin
            state_q  <= state_d;
            col_q    <= col_d;
            row_q    <= row_d;
            boot_q   <= 1'b0;
            busy     <= (state_d == ST_CLEAR) || (state_d == ST_SCROLL) ||
                        (state_d == ST_SCROLL_BLANK);
            ch_ready <= (state_d == ST_IDLE);
        end
    end

    vram_fill_copy u_engine (
        .clk       (clk_pixel),
        .rst_n     (clk_locked),
        .start     (eng_start),
        .copy      (eng_copy),
        .src       (eng_src),
        .dst       (eng_dst),
        .len       (eng_len),
        .fill_data (eng_fill),
        .rd_din    (rd_din),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .done      (eng_done)
    );

endmodule

// File: tb/tb_text_console_writer.sv
// tb/tb_text_console_writer.sv - scoreboard bench for text_console_writer
module tb_text_console_writer;
    import video_pkg::*;

    localparam int LIMIT = 6000;

    logic        clk_pixel  = 1'b0;
    logic        clk_locked = 1'b0;
    logic [7:0]  ch_data    = 8'h00;
    logic        ch_valid   = 1'b0;
    logic        ch_ready;
    logic [15:0] wr_addr;
    logic [7:0]  wr_data;
    logic        wr_en;
    logic [15:0] rd_addr;
    logic        rd_en;
    logic [7:0]  rd_din     = 8'h00;
    logic [5:0]  cursor_col;
    logic [5:0]  cursor_row;
    logic        busy;

    int          n_cmp = 0;
    int          n_err = 0;
    logic [23:0] exp_q[$];
    logic [23:0] mon_e;
    logic [7:0]  vram    [0:2559];
    logic [7:0]  exp_mem [0:2559];
    int          m_col = 0;
    int          m_row = 0;
    int          bc;
    int          n;
    bit          rdy_seen;

    always #5 clk_pixel = ~clk_pixel;

    text_console_writer dut (
        .clk_pixel  (clk_pixel),
        .clk_locked (clk_locked),
        .ch_data    (ch_data),
        .ch_valid   (ch_valid),
        .ch_ready   (ch_ready),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_en      (wr_en),
        .rd_addr    (rd_addr),
        .rd_en      (rd_en),
        .rd_din     (rd_din),
        .cursor_col (cursor_col),
        .cursor_row (cursor_row),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic check_cursor(input string tag, input int row, input int col);
        @(negedge clk_pixel);
        check(tag, {20'h0, cursor_row, cursor_col}, {20'h0, 6'(row), 6'(col)});
    endtask

    // Reference model of the screen: every expected write goes onto the scoreboard queue
    task automatic push_wr(input int idx, input logic [7:0] d);
        exp_mem[idx] = d;
        exp_q.push_back({BASE_ADDR + 16'(idx), d});
    endtask

    task automatic model_clear();
        for (int i = 0; i < COLS * ROWS; i++) push_wr(i, FILL_CHAR);
        m_col = 0;
        m_row = 0;
    endtask

    task automatic model_scroll();
        for (int i = 0; i < COLS * (ROWS - 1); i++) push_wr(i, exp_mem[i + COLS]);
        for (int i = 0; i < COLS; i++) push_wr(COLS * (ROWS - 1) + i, FILL_CHAR);
        m_col = 0;
        m_row = ROWS - 1;
    endtask

    task automatic model_char(input logic [7:0] c);
        case (c)
            CC_CR: m_col = 0;
            CC_BS: if (m_col > 0) m_col--;
            CC_FF: model_clear();
            CC_LF: begin
                if (m_row < ROWS - 1) m_row++;
                else model_scroll();
            end
            default: begin
                push_wr(m_row * COLS + m_col, c);
                if (m_col < COLS - 1) begin
                    m_col++;
                end else begin
                    m_col = 0;
                    if (m_row < ROWS - 1) m_row++;
                    else model_scroll();
                end
            end
        endcase
    endtask

    function automatic bit is_ctrl(input logic [7:0] c);
        return (c == CC_CR) || (c == CC_BS) || (c == CC_FF) || (c == CC_LF);
    endfunction

    task automatic send(input logic [7:0] c);
        int k = 0;
        @(negedge clk_pixel);
        ch_data  = c;
        ch_valid = 1'b1;
        while (ch_ready !== 1'b1 && k < LIMIT) begin
            @(negedge clk_pixel);
            k++;
        end
        check("send_ready", 32'(ch_ready), 32'd1);
        model_char(c);
        @(posedge clk_pixel);
        #1;
        ch_valid = 1'b0;
        if (!is_ctrl(c)) begin
            @(negedge clk_pixel);
            check("put_latency_wr_en", 32'(wr_en), 32'd1);
        end
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        @(negedge clk_pixel);
        while (ch_ready !== 1'b1 && k < LIMIT) begin
            @(negedge clk_pixel);
            k++;
        end
        check({tag, "_ready"}, 32'(ch_ready), 32'd1);
        check({tag, "_drained"}, 32'(exp_q.size()), 32'd0);
    endtask

    // Scoreboard: each DUT write is popped against the oldest expected write
    always @(negedge clk_pixel) begin
        if (wr_en === 1'b1) begin
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("write_addr", 32'(wr_addr), 32'(mon_e[23:8]));
                check("write_data", 32'(wr_data), 32'(mon_e[7:0]));
            end
        end
    end

    // Video RAM with a one-cycle synchronous read port
    always @(posedge clk_pixel) begin
        if (wr_en === 1'b1 && wr_addr >= BASE_ADDR) vram[wr_addr - BASE_ADDR] <= wr_data;
        if (rd_en === 1'b1 && rd_addr >= BASE_ADDR) rd_din <= vram[rd_addr - BASE_ADDR];
    end

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state and the boot-time clear
        model_clear();
        repeat (3) @(negedge clk_pixel);
        check("reset_wr_en", 32'(wr_en), 32'd0);
        check("reset_rd_en", 32'(rd_en), 32'd0);
        check("reset_ch_ready", 32'(ch_ready), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_cursor", {20'h0, cursor_row, cursor_col}, 32'd0);
        check("reset_addr_data", {8'h0, wr_addr, wr_data}, 32'd0);
        check("reset_rd_addr", 32'(rd_addr), 32'd0);
        clk_locked = 1'b1;
        wait_idle("boot_clear");
        check_cursor("boot_cursor", 0, 0);

        // Two printable characters, then BS mid-row and CR
        send(8'h41);
        send(8'h42);
        check_cursor("ab_cursor", 0, 2);
        send(CC_BS);
        check_cursor("bs_mid_row", 0, 1);
        send(CC_CR);
        check_cursor("cr_to_col0", 0, 0);

        // One full row wraps the cursor; CR and BS at column 0 do nothing
        for (int i = 0; i < COLS; i++) send(8'h78);
        check_cursor("row_wrap", 1, 0);
        send(CC_CR);
        send(CC_BS);
        check_cursor("cr_bs_at_col0", 1, 0);

        // Form feed mid-screen while a held character waits for ready
        send(CC_FF);
        @(negedge clk_pixel);
        ch_data  = 8'h51;
        ch_valid = 1'b1;
        check("ff_busy", 32'(busy), 32'd1);
        n = 0;
        while (ch_ready !== 1'b1 && n < LIMIT) begin
            @(negedge clk_pixel);
            n++;
        end
        check("ff_hold_ready", 32'(ch_ready), 32'd1);
        check("ff_clear_drained", 32'(exp_q.size()), 32'd0);
        check("ff_cursor", {20'h0, cursor_row, cursor_col}, 32'd0);
        model_char(8'h51);
        @(posedge clk_pixel);
        #1;
        ch_valid = 1'b0;
        @(negedge clk_pixel);
        check("held_char_written", 32'(wr_en), 32'd1);
        check_cursor("after_held_char", 0, 1);

        // Fill rows 0..38 with row-tagged characters, row 39 partly, then scroll via LF
        send(CC_CR);
        for (int r = 0; r < ROWS - 1; r++)
            for (int c = 0; c < COLS; c++) send(8'(r + 8'h30));
        for (int c = 0; c < COLS - 1; c++) send(8'h57);
        send(CC_CR);
        check_cursor("pre_scroll", 39, 0);
        send(CC_LF);
        bc       = 0;
        rdy_seen = 1'b0;
        n        = 0;
        @(negedge clk_pixel);
        while (busy === 1'b1 && n < LIMIT) begin
            bc++;
            if (ch_ready === 1'b1) rdy_seen = 1'b1;
            @(negedge clk_pixel);
            n++;
        end
        check("scroll_busy_cycles", 32'(bc), 32'd2561);
        check("scroll_ready_low", 32'(rdy_seen), 32'd0);
        check("scroll_drained", 32'(exp_q.size()), 32'd0);
        check("scroll_cursor", {20'h0, cursor_row, cursor_col}, {20'h0, 6'd39, 6'd0});
        check("scroll_row0", 32'(vram[0]), 32'h31);
        check("scroll_row38_c62", 32'(vram[38 * 64 + 62]), 32'h57);
        check("scroll_row38_c63", 32'(vram[38 * 64 + 63]), 32'h20);
        check("scroll_row39_c0", 32'(vram[39 * 64]), 32'h20);

        // The last cell of the screen is written and then scrolls
        for (int c = 0; c < COLS; c++) send(8'h5A);
        wait_idle("last_cell_scroll");
        check_cursor("last_cell_cursor", 39, 0);
        check("last_cell_row38", 32'(vram[38 * 64 + 63]), 32'h5A);

        // Reset in the middle of a scroll aborts at once and restarts the clear
        send(CC_LF);
        repeat (100) @(negedge clk_pixel);
        check("mid_scroll_rd_en", 32'(rd_en), 32'd1);
        #2;
        clk_locked = 1'b0;
        #1;
        check("abort_wr_en", 32'(wr_en), 32'd0);
        check("abort_rd_en", 32'(rd_en), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_ready", 32'(ch_ready), 32'd0);
        exp_q.delete();
        model_clear();
        repeat (3) @(negedge clk_pixel);
        clk_locked = 1'b1;
        wait_idle("clear_after_abort");
        check_cursor("abort_cursor", 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
